// File: rtl/debounce_pkg.sv
// debounce_pkg: shared definitions for the debouncer FSM.
//   state_t - four-state encoding; the bench reuses the ST_* names for
//             state checks, so the values are fixed:
//             ST_ZERO=00, ST_WAIT1=01, ST_ONE=10, ST_WAIT0=11.
//   Bit 1 of the encoding is the debounced level (set in ONE and WAIT0).
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_WAIT1 = 2'b01,
    ST_ONE   = 2'b10,
    ST_WAIT0 = 2'b11
  } state_t;

  // The debounced level is a pure function of the registered state.
  function automatic logic state_level(input state_t st);
    return st[1];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
//   clk   - sampling clock
//   reset - synchronous, active-high; clears both flops
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debouncer.sv
// debouncer: turns a bouncy switch input into a clean registered level.
//   A new level is accepted only after STABLE_CYCLES consecutive identical
//   samples; any disagreeing sample aborts the wait and the count restarts.
//
// Parameters:
//   STABLE_CYCLES - samples required to accept a new level (>= 2)
//   CNT_WIDTH     - counter width, STABLE_CYCLES <= 2**CNT_WIDTH - 1
// Ports:
//   clk       - clock, all state on the rising edge
//   reset     - synchronous, active-high
//   sw        - raw switch input
//   level     - debounced level (1 in ONE and WAIT0)
//   dbg_state - current FSM state, for observation
//   dbg_cnt   - current stability count, for observation
// Build option:
//   DEBOUNCER_SYNC_EN - when defined, sw passes through sync_2ff before the
//                       FSM, adding two cycles to both latencies.
//
// Handshake: none; sw is sampled every cycle and level is a plain level.
module debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sw,
  output logic                 level,
  output state_t               dbg_state,
  output logic [CNT_WIDTH-1:0] dbg_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s;
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

`ifdef DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (s)
  );
`else
  assign s = sw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ZERO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The first agreeing sample loads cnt=1, so reaching CNT_LAST means
  // STABLE_CYCLES agreeing samples have been seen. cnt never passes CNT_LAST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_ZERO: begin
        if (s) begin
          state_nxt = ST_WAIT1;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT1: begin
        if (!s) begin
          state_nxt = ST_ZERO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_ONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      ST_ONE: begin
        if (!s) begin
          state_nxt = ST_WAIT0;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT0: begin
        if (s) begin
          state_nxt = ST_ONE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_ZERO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // level comes straight from a state flop: no combinational path from sw.
  assign level     = state_level(state);
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_debouncer.sv
// tb_debouncer: directed bench for debouncer with STABLE_CYCLES=4.
// Inputs change 1 ns after each rising edge; outputs are checked at that
// same point, i.e. they reflect the edge just taken.
module tb_debouncer;
  import debounce_pkg::*;

  localparam int SC = 4;
  localparam int CW = 3;
`ifdef DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sw = 1'b0;
  logic          level;
  state_t        dbg_state;
  logic [CW-1:0] dbg_cnt;

  int tests = 0;
  int fails = 0;
  int rises = 0;
  logic level_d = 1'b0;

  debouncer #(.STABLE_CYCLES(SC), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .level     (level),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Rising-edge detector model on level, standing in for the downstream tick.
  always @(negedge clk) begin
    if (level && !level_d) rises++;
    level_d = level;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v);
    reset = 1'b1;
    sw    = v;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scenario 1: reset held with sw high, then a full qualification run.
  task automatic test_reset();
    reset = 1'b1;
    sw    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (level !== 1'b0 || dbg_state !== ST_ZERO) begin
        fails++;
        $display("FAIL reset_hold[%0d]: level=%b state=%0d, want level=0 state=0", i, level, dbg_state);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < SC + LAT; i++) begin
      step();
      tests++;
      if (level !== (i >= SC + LAT - 1)) begin
        fails++;
        $display("FAIL reset_release[%0d]: level=%b want %b", i, level, (i >= SC + LAT - 1));
      end
    end
  endtask

  // Scenario 2 (and 6 with the synchronizer): steady press, one tick.
  task automatic test_press();
    int r0;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step();
    r0 = rises;
    sw = 1'b1;
    for (int i = 0; i < SC + LAT + 5; i++) begin
      step();
      tests++;
      if (level !== (i >= SC + LAT - 1)) begin
        fails++;
        $display("FAIL press[%0d]: level=%b want %b", i, level, (i >= SC + LAT - 1));
      end
    end
    tests++;
    if (rises - r0 != 1) begin
      fails++;
      $display("FAIL press_ticks: got %0d want 1", rises - r0);
    end
  endtask

  // Scenario 3: 1,1,0,1,1,1,1 - the break restarts the count from 1.
  task automatic test_bounce();
    logic [6:0] pat;
    logic [6:0] exp_lvl;
    logic [CW-1:0] exp_cnt [7];
    pat     = 7'b1111011;   // bit i = sample i
    exp_lvl = 7'b1000000;
    exp_cnt = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    do_reset(1'b0);
    step();
    for (int i = 0; i < 7; i++) begin
      sw = pat[i];
      step();
      tests++;
      if (level !== exp_lvl[i] || dbg_cnt !== exp_cnt[i]) begin
        fails++;
        $display("FAIL bounce[%0d]: level=%b cnt=%0d want level=%b cnt=%0d",
                 i, level, dbg_cnt, exp_lvl[i], exp_cnt[i]);
      end
    end
  endtask

  // Scenario 4: short low glitch ignored, then a full release.
  task automatic test_release();
    do_reset(1'b1);
    sw = 1'b1;
    for (int i = 0; i < SC; i++) step();
    tests++;
    if (dbg_state !== ST_ONE || level !== 1'b1) begin
      fails++;
      $display("FAIL release_setup: state=%0d level=%b want state=2 level=1", dbg_state, level);
    end
    for (int i = 0; i < 3; i++) begin
      sw = 1'b0;
      step();
      tests++;
      if (level !== 1'b1 || dbg_state !== ST_WAIT0) begin
        fails++;
        $display("FAIL release_glitch[%0d]: level=%b state=%0d want level=1 state=3", i, level, dbg_state);
      end
    end
    sw = 1'b1;
    step();
    tests++;
    if (level !== 1'b1 || dbg_state !== ST_ONE) begin
      fails++;
      $display("FAIL release_back: level=%b state=%0d want level=1 state=2", level, dbg_state);
    end
    for (int i = 0; i < SC; i++) begin
      sw = 1'b0;
      step();
      tests++;
      if (level !== (i < SC - 1)) begin
        fails++;
        $display("FAIL release_fall[%0d]: level=%b want %b", i, level, (i < SC - 1));
      end
    end
    tests++;
    if (dbg_state !== ST_ZERO) begin
      fails++;
      $display("FAIL release_state: state=%0d want 0", dbg_state);
    end
  endtask

  // Scenario 5: reset mid-WAIT1 dominates and forces a full requalification.
  task automatic test_reset_mid_wait();
    do_reset(1'b0);
    sw = 1'b1;
    step();
    step();
    tests++;
    if (dbg_state !== ST_WAIT1 || dbg_cnt !== 3'd2) begin
      fails++;
      $display("FAIL midwait_setup: state=%0d cnt=%0d want state=1 cnt=2", dbg_state, dbg_cnt);
    end
    reset = 1'b1;
    step();
    tests++;
    if (dbg_state !== ST_ZERO || dbg_cnt !== 3'd0 || level !== 1'b0) begin
      fails++;
      $display("FAIL midwait_reset: state=%0d cnt=%0d level=%b want 0/0/0", dbg_state, dbg_cnt, level);
    end
    reset = 1'b0;
    for (int i = 0; i < SC; i++) begin
      step();
      tests++;
      if (level !== (i >= SC - 1)) begin
        fails++;
        $display("FAIL midwait_requal[%0d]: level=%b want %b", i, level, (i >= SC - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
`ifndef DEBOUNCER_SYNC_EN
    test_bounce();
    test_release();
    test_reset_mid_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
